// File: rtl/reg_word_unpacker_pkg.sv
// Shared definitions for reg_word_unpacker: state encoding and a clog2 helper.
package reg_word_unpacker_pkg;

  localparam logic UNPACK_STATE_IDLE  = 1'b0;
  localparam logic UNPACK_STATE_SHIFT = 1'b1;

  typedef enum logic {
    ST_IDLE  = UNPACK_STATE_IDLE,
    ST_SHIFT = UNPACK_STATE_SHIFT
  } unpack_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_word_unpacker.sv
// Pops IN_WIDTH-bit words from an empty/rd_en source and streams them as OUT_WIDTH chunks.
// Optional macro UNPACK_MSB_FIRST_EN: emit the most significant chunk first.
module reg_word_unpacker
  import reg_word_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 empty,
  output logic                 rd_en,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy
);

  localparam int NCHUNKS = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W   = clog2(NCHUNKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNKS - 1);

  if (((IN_WIDTH % OUT_WIDTH) != 0) || (NCHUNKS < 2)) begin : g_bad_cfg
    $error("reg_word_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 chunks");
  end

  unpack_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]    hold_q, hold_d;
  logic [OUT_WIDTH-1:0]   dout_q, dout_d;
  logic                   rd_en_c;

  function automatic logic [OUT_WIDTH-1:0] chunk_sel(input logic [IN_WIDTH-1:0] word,
                                                     input logic [CNT_W-1:0]    k);
    int pos;
`ifdef UNPACK_MSB_FIRST_EN
    pos = (NCHUNKS - 1 - int'(k)) * OUT_WIDTH;
`else
    pos = int'(k) * OUT_WIDTH;
`endif
    return OUT_WIDTH'(word >> pos);
  endfunction

  // dout_d is the chunk that will be presented next cycle, so dout itself is a flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    rd_en_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_en_c = ~empty;
        if (!empty) begin
          hold_d  = din;
          cnt_d   = '0;
          dout_d  = chunk_sel(din, '0);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (dout_ready) begin
          if (cnt_q != LAST_CNT) begin
            cnt_d  = cnt_q + 1'b1;
            dout_d = chunk_sel(hold_q, cnt_q + 1'b1);
          end else if (!empty) begin
            rd_en_c = 1'b1;
            hold_d  = din;
            cnt_d   = '0;
            dout_d  = chunk_sel(din, '0);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
    end
  end

  // Gating with rst_n keeps the source from being popped while reset is held
  assign rd_en      = rd_en_c & rst_n;
  assign dout       = dout_q;
  assign dout_valid = (state_q == ST_SHIFT);
  assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_reg_word_unpacker.sv
// Self-checking bench for reg_word_unpacker: vector table, hand sequences, randomized model run.
module tb_reg_word_unpacker;

  localparam int IW = 64;
  localparam int OW = 16;
  localparam int NC = IW / OW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] din;
  logic          empty;
  logic          rd_en;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;

  always #5 clk = ~clk;

  reg_word_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .empty      (empty),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Chunk k of a word in emission order, from the word's lane layout.
  function automatic logic [OW-1:0] exp_chunk(input logic [IW-1:0] w, input int k);
    logic [OW-1:0] lanes [NC];
    for (int j = 0; j < NC; j++) lanes[j] = w[OW*j +: OW];
`ifdef UNPACK_MSB_FIRST_EN
    return lanes[NC-1-k];
`else
    return lanes[k];
`endif
  endfunction

  typedef struct {
    logic [IW-1:0] w;
    logic [OW-1:0] lsb_order [NC];
  } vec_t;

  vec_t tbl [3];

  logic [OW-1:0]  exp_q [$];
  logic [IW-1:0]  src_q [$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] w1, w2;
    logic [OW-1:0] got [$];
    int            rd_cyc [$];
    int            pops, vcount, cyc;
    logic          xfer, exp_rd, hold_empty;

    tbl[0].w = 64'h4444_3333_2222_1111;
    tbl[0].lsb_order = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    tbl[1].w = 64'hDEAD_BEEF_0123_4567;
    tbl[1].lsb_order = '{16'h4567, 16'h0123, 16'hBEEF, 16'hDEAD};
    tbl[2].w = 64'hFFFF_0000_8001_7FFE;
    tbl[2].lsb_order = '{16'h7FFE, 16'h8001, 16'h0000, 16'hFFFF};

    // Reset state, with a word offered to prove no pop during reset
    rst_n = 1'b0; empty = 1'b1; din = '0; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    empty = 1'b0; din = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk); empty = 1'b1; rst_n = 1'b1;

    // Table vectors: single word, ready held high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); din = tbl[i].w; empty = 1'b0; dout_ready = 1'b1; #1;
      chk("tbl_pop_rd_en", rd_en, 1);
      for (int k = 0; k < NC; k++) begin
        @(negedge clk); empty = 1'b1; #1;
        chk("tbl_valid", dout_valid, 1);
        chk("tbl_rd_en_quiet", rd_en, 0);
`ifdef UNPACK_MSB_FIRST_EN
        chk("tbl_dout", dout, tbl[i].lsb_order[NC-1-k]);
`else
        chk("tbl_dout", dout, tbl[i].lsb_order[k]);
`endif
      end
      @(negedge clk); #1;
      chk("tbl_valid_falls", dout_valid, 0);
      chk("tbl_busy_falls", busy, 0);
    end

    // Two queued words: eight chunks with no gap, pops on cycles 0 and 4
    w1 = 64'h4444_3333_2222_1111;
    w2 = 64'h8888_7777_6666_5555;
    pops = 0; vcount = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      dout_ready = 1'b1;
      din   = (pops == 0) ? w1 : w2;
      empty = (pops >= 2);
      #1;
      if (rd_en) rd_cyc.push_back(c);
      if (dout_valid) begin
        got.push_back(dout);
        if (c >= 1 && c <= 8) vcount++;
      end
      if (rd_en && !empty) pops++;
    end
    chk("b2b_rd_en_count", rd_cyc.size(), 2);
    if (rd_cyc.size() == 2) begin
      chk("b2b_rd_en_first", rd_cyc[0], 0);
      chk("b2b_rd_en_second", rd_cyc[1], 4);
    end
    chk("b2b_no_gap", vcount, 8);
    chk("b2b_chunk_count", got.size(), 8);
    if (got.size() == 8) begin
      for (int k = 0; k < 8; k++)
        chk("b2b_dout", got[k], exp_chunk((k < 4) ? w1 : w2, k % 4));
    end

    // Stall on chunk 1: ready 1,0,0,1
    w1 = 64'h4444_3333_2222_1111;
    @(negedge clk); din = w1; empty = 1'b0; dout_ready = 1'b1; #1;
    chk("stall_pop", rd_en, 1);
    @(negedge clk); empty = 1'b1; dout_ready = 1'b1; #1;
    chk("stall_chunk0", dout, exp_chunk(w1, 0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); dout_ready = (c == 2); #1;
      chk("stall_hold_dout", dout, exp_chunk(w1, 1));
      chk("stall_hold_valid", dout_valid, 1);
      chk("stall_no_rd_en", rd_en, 0);
    end
    @(negedge clk); dout_ready = 1'b1; #1;
    chk("stall_chunk2", dout, exp_chunk(w1, 2));
    @(negedge clk); #1;
    chk("stall_chunk3", dout, exp_chunk(w1, 3));
    @(negedge clk); #1;
    chk("stall_done", dout_valid, 0);

    // Asynchronous reset mid-word, then a fresh word
    @(negedge clk); din = w1; empty = 1'b0; dout_ready = 1'b1; #1;
    @(negedge clk); empty = 1'b1; #1;
    @(negedge clk); #1;
    chk("arst_pre_chunk1", dout, exp_chunk(w1, 1));
    @(negedge clk); #1;
    #2;
    din = 64'hAAAA_BBBB_CCCC_DDDD; empty = 1'b0;
    rst_n = 1'b0; #1;
    chk("arst_valid", dout_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", rd_en, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("arst_release_pop", rd_en, 1);
    @(negedge clk); empty = 1'b1; #1;
    chk("arst_first_valid", dout_valid, 1);
    chk("arst_first_dout", dout, exp_chunk(64'hAAAA_BBBB_CCCC_DDDD, 0));
    repeat (NC) @(negedge clk);
    #1;
    chk("arst_drained", dout_valid, 0);

    // Empty held for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); empty = 1'b1; dout_ready = 1'($urandom_range(0, 1)); #1;
      chk("idle_rd_en", rd_en, 0);
      chk("idle_valid", dout_valid, 0);
    end

    // Randomized run against a chunk-queue model
    for (int i = 0; i < 40; i++) src_q.push_back({$urandom, $urandom});
    cyc = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      dout_ready = ($urandom_range(0, 3) != 0);
      hold_empty = ($urandom_range(0, 4) == 0);
      empty      = (src_q.size() == 0) || hold_empty;
      din        = (src_q.size() != 0) ? src_q[0] : {$urandom, $urandom};
      #1;
      xfer   = dout_valid && dout_ready;
      exp_rd = !empty && (exp_q.size() == 0 || (exp_q.size() == 1 && xfer));
      chk("rnd_valid", dout_valid, (exp_q.size() != 0));
      chk("rnd_busy", busy, (exp_q.size() != 0));
      chk("rnd_rd_en", rd_en, exp_rd);
      if (xfer && exp_q.size() != 0) chk("rnd_dout", dout, exp_q.pop_front());
      if (rd_en && !empty) begin
        for (int k = 0; k < NC; k++) exp_q.push_back(exp_chunk(din, k));
        void'(src_q.pop_front());
      end
      cyc++;
    end
    chk("rnd_all_consumed", src_q.size() + exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
